// File: rtl/dmem_pkg.sv
// dmem_pkg: shared SIZE encodings, FSM state encoding and wait-counter width for dmem_ctrl
package dmem_pkg;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam int         WCNT_W  = 4;
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_RDATA, S_ACK} state_t;
endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: big-endian lane steering for one data-bus access.
// Ports: size/off (SIZE code, byte offset) and wdata_i (right-justified store data) in;
// be (byte enables, be[3] = bits 31:24), wdata_o (lane-replicated data) and mis (misaligned) out.
// A reserved SIZE code behaves as a word.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be,
    output logic [31:0] wdata_o,
    output logic        mis
);
    always_comb begin
        be      = size == SZ_HALF ? (off[1] ? 4'b0011 : 4'b1100)
                : size == SZ_BYTE ? 4'b1000 >> off : 4'b1111;
        wdata_o = size == SZ_HALF ? {2{wdata_i[15:0]}}
                : size == SZ_BYTE ? {4{wdata_i[7:0]}} : wdata_i;
        mis     = size == SZ_HALF ? off[0] : size == SZ_BYTE ? 1'b0 : |off;
    end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-side memory controller between the pipeline data bus and a word-wide SRAM.
// Ports: clk, rst (sync, active-low); bus side DAD/MREQ/WRITE/SIZE/DDT_W in, DDT_R/DDT_OE/ACKD_n out;
// SRAM side ram_en/ram_we/ram_be/ram_addr/ram_wdata out, ram_rdata in (1-cycle read latency).
// Optional macro DMEM_ERR_EN adds output err and rejects misaligned requests.
// All outputs are registered from the current state, so each state's effect appears one
// cycle later: ram_en is up while the FSM sits in RDATA/ACK, and the read word is captured
// as the ACK pulse is launched.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       DAD,
    input  logic              MREQ,
    input  logic              WRITE,
    input  logic [1:0]        SIZE,
    input  logic [31:0]       DDT_W,
    output logic [31:0]       DDT_R,
    output logic              DDT_OE,
    output logic              ACKD_n,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
`ifdef DMEM_ERR_EN
    ,
    output logic              err
`endif
);
    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [31:0]       dad_q, dad_d, wd_q, wd_d;
    logic [1:0]        size_q, size_d;
    logic              wr_q, wr_d;
    logic              ackd_n_q, ackd_n_d, oe_q, oe_d, en_q, en_d, we_q, we_d;
    logic [31:0]       ddt_r_q, ddt_r_d, wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic              lane_mis, hit, go;

    dmem_lane u_lane (
        .size    (size_q),
        .off     (dad_q[1:0]),
        .wdata_i (wd_q),
        .be      (lane_be),
        .wdata_o (lane_wdata),
        .mis     (lane_mis)
    );

    assign hit = dad_q[31:ADDR_W+2] == BASE[31:ADDR_W+2];
`ifdef DMEM_ERR_EN
    logic err_q, err_d;
    assign go  = hit && !lane_mis;
    assign err = err_q;
`else
    // Misalignment is absorbed by the lane rule: word enables ignore the offset, half uses DAD[1].
    logic unused_mis;
    assign go         = hit;
    assign unused_mis = lane_mis;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            dad_q    <= '0;
            wd_q     <= '0;
            size_q   <= '0;
            wr_q     <= 1'b0;
            ackd_n_q <= 1'b1;
            oe_q     <= 1'b0;
            ddt_r_q  <= '0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef DMEM_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            dad_q    <= dad_d;
            wd_q     <= wd_d;
            size_q   <= size_d;
            wr_q     <= wr_d;
            ackd_n_q <= ackd_n_d;
            oe_q     <= oe_d;
            ddt_r_q  <= ddt_r_d;
            en_q     <= en_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`ifdef DMEM_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        dad_d   = dad_q;
        wd_d    = wd_q;
        size_d  = size_q;
        wr_d    = wr_q;
        unique case (state_q)
            S_IDLE: if (MREQ) begin
                dad_d   = DAD;
                wd_d    = DDT_W;
                size_d  = SIZE;
                wr_d    = WRITE;
                wcnt_d  = WCNT_W'(WAIT_CYCLES);
                state_d = WAIT_CYCLES > 0 ? S_WAIT : S_ACCESS;
            end
            S_WAIT: begin
                wcnt_d  = wcnt_q - 1'b1;
                state_d = wcnt_q <= WCNT_W'(1) ? S_ACCESS : S_WAIT;
            end
            S_ACCESS: state_d = wr_q ? S_ACK : S_RDATA;
            S_RDATA:  state_d = S_ACK;
            S_ACK:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        en_d     = state_q == S_ACCESS && go;
        we_d     = en_d && wr_q;
        be_d     = en_d ? (wr_q ? lane_be : 4'hf) : 4'h0;
        addr_d   = en_d ? dad_q[ADDR_W+1:2] : '0;
        wdata_d  = we_d ? lane_wdata : '0;
        ackd_n_d = state_q != S_ACK;
        oe_d     = state_q == S_ACK && !wr_q;
        // ram_rdata is valid in the ACK-state cycle, one cycle after ram_en.
        ddt_r_d  = oe_d ? (go ? ram_rdata : '0) : ddt_r_q;
`ifdef DMEM_ERR_EN
        err_d    = state_q == S_ACK && !go;
`endif
    end

    assign DDT_R     = ddt_r_q;
    assign DDT_OE    = oe_q;
    assign ACKD_n    = ackd_n_q;
    assign ram_en    = en_q;
    assign ram_we    = we_q;
    assign ram_be    = be_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl (table vectors, reset/back-to-back sequences, random vs model)
module tb_dmem_ctrl;
    localparam int AW = 12;
    localparam int WC = 1;
`ifdef DMEM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] DAD = '0, DDT_W = '0, DDT_R, ram_wdata, ram_rdata = '0;
    logic        MREQ = 1'b0, WRITE = 1'b0, DDT_OE, ACKD_n, ram_en, ram_we;
    logic [1:0]  SIZE = '0;
    logic [3:0]  ram_be;
    logic [AW-1:0] ram_addr;
`ifdef DMEM_ERR_EN
    logic err, err_b;
`endif

    logic [31:0] DAD_b = '0, DDT_R_b, ram_wdata_b, ram_rdata_b = '0;
    logic        MREQ_b = 1'b0, DDT_OE_b, ACKD_n_b, ram_en_b, ram_we_b;
    logic [3:0]  ram_be_b;
    logic [AW-1:0] ram_addr_b;

    dmem_ctrl #(.ADDR_W(AW), .BASE(32'h0), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
        .DDT_W(DDT_W), .DDT_R(DDT_R), .DDT_OE(DDT_OE), .ACKD_n(ACKD_n),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef DMEM_ERR_EN
        , .err(err)
`endif
    );

    dmem_ctrl #(.ADDR_W(AW), .BASE(32'h0), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .DAD(DAD_b), .MREQ(MREQ_b), .WRITE(1'b0), .SIZE(2'b00),
        .DDT_W(32'h0), .DDT_R(DDT_R_b), .DDT_OE(DDT_OE_b), .ACKD_n(ACKD_n_b),
        .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_be(ram_be_b), .ram_addr(ram_addr_b),
        .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b)
`ifdef DMEM_ERR_EN
        , .err(err_b)
`endif
    );

    // SRAM seen by the main DUT: word wide, byte-enabled, one-cycle read latency
    logic [31:0] sram [0:(1<<AW)-1];
    always @(posedge clk) if (ram_en) begin
        if (ram_we) for (int i = 0; i < 4; i++) if (ram_be[i]) sram[ram_addr][8*i+:8] <= ram_wdata[8*i+:8];
        ram_rdata <= sram[ram_addr];
    end

    // Reference model: byte-addressed shadow of the window, big-endian
    logic [7:0] shadow [0:(4<<AW)-1];

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model(input logic [31:0] a, input logic w, input logic [1:0] s, input logic [31:0] d,
                         output bit acc, output logic [3:0] be, output logic [31:0] wdat,
                         output logic [31:0] rdat, output logic [AW-1:0] ra);
        int n, start, off, base;
        n     = s == 2'b01 ? 2 : s == 2'b10 ? 1 : 4;
        acc   = (a < 32'(4 << AW)) && !(ERR && (a % n) != 0);
        start = int'(a[AW+1:0]) - int'(a[AW+1:0]) % n;
        off   = start % 4;
        base  = start - off;
        ra    = AW'(base / 4);
        be    = w ? 4'h0 : 4'hf;
        if (w) for (int i = 0; i < n; i++) be[3-off-i] = 1'b1;
        for (int j = 0; j < 4; j++) wdat[8*(3-j)+:8] = d[8*(n-1-(j%n))+:8];
        if (acc && w) for (int i = 0; i < n; i++) shadow[start+i] = d[8*(n-1-i)+:8];
        rdat = '0;
        if (acc && !w) for (int j = 0; j < 4; j++) rdat[8*(3-j)+:8] = shadow[base+j];
    endtask

    typedef struct {
        int lat; int n_en; logic [3:0] be; logic [AW-1:0] ra; logic [31:0] wd;
        logic we; logic [31:0] rd; logic oe; logic er; logic rel;
    } obs_t;

    // One request; bus inputs are scrambled while the access is in flight
    task automatic xact(input logic [31:0] a, input logic w, input logic [1:0] s, input logic [31:0] d, output obs_t o);
        o.lat = -1; o.n_en = 0; o.be = '0; o.ra = '0; o.wd = '0; o.we = 1'b0;
        o.rd = '0; o.oe = 1'b0; o.er = 1'b0; o.rel = 1'b0;
        @(negedge clk);
        DAD = a; WRITE = w; SIZE = s; DDT_W = d; MREQ = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            if (ram_en) begin
                o.n_en++; o.be = ram_be; o.ra = ram_addr; o.wd = ram_wdata; o.we = ram_we;
            end
            if (!ACKD_n) begin
                o.lat = k; o.rd = DDT_R; o.oe = DDT_OE;
`ifdef DMEM_ERR_EN
                o.er = err;
`endif
                break;
            end
            MREQ = 1'($urandom); DAD = $urandom; WRITE = 1'($urandom); SIZE = 2'($urandom); DDT_W = $urandom;
            @(negedge clk);
        end
        MREQ = 1'b0;
        @(negedge clk);
        o.rel = ACKD_n && !DDT_OE;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " ACKD_n"}, 32'(ACKD_n), 32'd1);
        chk({tag, " DDT_OE"}, 32'(DDT_OE), 32'd0);
        chk({tag, " DDT_R"}, DDT_R, 32'd0);
        chk({tag, " ram_en"}, 32'(ram_en), 32'd0);
        chk({tag, " ram_we"}, 32'(ram_we), 32'd0);
        chk({tag, " ram_be"}, 32'(ram_be), 32'd0);
        chk({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, " ram_wdata"}, ram_wdata, 32'd0);
`ifdef DMEM_ERR_EN
        chk({tag, " err"}, 32'(err), 32'd0);
`endif
    endtask

    typedef struct {
        logic [31:0] a; logic w; logic [1:0] s; logic [31:0] d;
        int lat; int en; logic [3:0] be; logic [AW-1:0] ra; logic [31:0] wd; logic [31:0] rd; logic e;
    } vec_t;
    localparam int NV = 16;
    vec_t tv [NV];

    initial begin
        obs_t o;
        bit m_acc;
        logic [3:0] m_be;
        logic [31:0] m_wd, m_rd, a, d;
        logic [AW-1:0] m_ra;
        logic w, saw_we;
        logic [1:0] s;
        int acks[$];
        logic [AW-1:0] ens[$];

        tv[0]  = '{a:32'h10, w:1, s:2'b00, d:32'hDEADBEEF, lat:3, en:1, be:4'hf, ra:12'h4, wd:32'hDEADBEEF, rd:0, e:0};
        tv[1]  = '{a:32'h10, w:0, s:2'b00, d:0, lat:4, en:1, be:4'hf, ra:12'h4, wd:0, rd:32'hDEADBEEF, e:0};
        tv[2]  = '{a:32'h13, w:1, s:2'b10, d:32'hA5, lat:3, en:1, be:4'b0001, ra:12'h4, wd:32'hA5A5A5A5, rd:0, e:0};
        tv[3]  = '{a:32'h10, w:0, s:2'b00, d:0, lat:4, en:1, be:4'hf, ra:12'h4, wd:0, rd:32'hDEADBEA5, e:0};
        tv[4]  = '{a:32'h20, w:1, s:2'b01, d:32'h1234, lat:3, en:1, be:4'b1100, ra:12'h8, wd:32'h12341234, rd:0, e:0};
        tv[5]  = '{a:32'h22, w:1, s:2'b01, d:32'hABCD, lat:3, en:1, be:4'b0011, ra:12'h8, wd:32'hABCDABCD, rd:0, e:0};
        tv[6]  = '{a:32'h21, w:1, s:2'b10, d:32'h5A, lat:3, en:1, be:4'b0100, ra:12'h8, wd:32'h5A5A5A5A, rd:0, e:0};
        tv[7]  = '{a:32'h23, w:0, s:2'b10, d:0, lat:4, en:1, be:4'hf, ra:12'h8, wd:0, rd:32'h125AABCD, e:0};
        tv[8]  = '{a:32'h8000_0000, w:0, s:2'b00, d:0, lat:4, en:0, be:0, ra:0, wd:0, rd:0, e:1};
        tv[9]  = '{a:32'h8000_0010, w:1, s:2'b00, d:32'h55, lat:3, en:0, be:0, ra:0, wd:0, rd:0, e:1};
        tv[10] = '{a:32'h30, w:1, s:2'b11, d:32'h0BADF00D, lat:3, en:1, be:4'hf, ra:12'hC, wd:32'h0BADF00D, rd:0, e:0};
        tv[11] = '{a:32'h30, w:0, s:2'b00, d:0, lat:4, en:1, be:4'hf, ra:12'hC, wd:0, rd:32'h0BADF00D, e:0};
        tv[12] = '{a:32'h35, w:1, s:2'b00, d:32'h11223344, lat:3, en:int'(!ERR), be:4'hf, ra:12'hD, wd:32'h11223344, rd:0, e:ERR};
        tv[13] = '{a:32'h34, w:0, s:2'b00, d:0, lat:4, en:1, be:4'hf, ra:12'hD, wd:0, rd:ERR ? 32'h0 : 32'h11223344, e:0};
        tv[14] = '{a:32'h3B, w:1, s:2'b01, d:32'h7788, lat:3, en:int'(!ERR), be:4'b0011, ra:12'hE, wd:32'h77887788, rd:0, e:ERR};
        tv[15] = '{a:32'h38, w:0, s:2'b00, d:0, lat:4, en:1, be:4'hf, ra:12'hE, wd:0, rd:ERR ? 32'h0 : 32'h00007788, e:0};

        for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
        for (int i = 0; i < (4 << AW); i++) shadow[i] = '0;

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            model(tv[i].a, tv[i].w, tv[i].s, tv[i].d, m_acc, m_be, m_wd, m_rd, m_ra);
            xact(tv[i].a, tv[i].w, tv[i].s, tv[i].d, o);
            chk($sformatf("v%0d latency", i), 32'(o.lat), 32'(tv[i].lat));
            chk($sformatf("v%0d ram_en count", i), 32'(o.n_en), 32'(tv[i].en));
            if (tv[i].en != 0) begin
                chk($sformatf("v%0d ram_be", i), 32'(o.be), 32'(tv[i].be));
                chk($sformatf("v%0d ram_addr", i), 32'(o.ra), 32'(tv[i].ra));
                chk($sformatf("v%0d ram_we", i), 32'(o.we), 32'(tv[i].w));
                if (tv[i].w) chk($sformatf("v%0d ram_wdata", i), o.wd, tv[i].wd);
            end
            chk($sformatf("v%0d DDT_OE", i), 32'(o.oe), 32'(!tv[i].w));
            if (!tv[i].w) chk($sformatf("v%0d DDT_R", i), o.rd, tv[i].rd);
            chk($sformatf("v%0d ack release", i), 32'(o.rel), 32'd1);
`ifdef DMEM_ERR_EN
            chk($sformatf("v%0d err", i), 32'(o.er), 32'(tv[i].e));
`endif
        end

        // Reset while a write sits in WAIT: the write must never reach the SRAM
        @(negedge clk);
        DAD = 32'h40; WRITE = 1'b1; SIZE = 2'b00; DDT_W = 32'hCAFEF00D; MREQ = 1'b1;
        @(negedge clk);
        MREQ = 1'b0; rst = 1'b0; saw_we = ram_we;
        @(negedge clk);
        saw_we |= ram_we;
        chk_reset("mid reset");
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            saw_we |= ram_we;
        end
        chk("mid reset no ram_we", 32'(saw_we), 32'd0);
        xact(32'h40, 1'b0, 2'b00, 32'h0, o);
        chk("post reset latency", 32'(o.lat), 32'(WC + 3));
        chk("post reset ram_en count", 32'(o.n_en), 32'd1);
        chk("post reset DDT_R", o.rd, 32'h0);
        chk("post reset DDT_OE", 32'(o.oe), 32'd1);

        for (int t = 0; t < 150; t++) begin
            a = $urandom_range(0, 4) == 0 ? ($urandom | 32'h0001_0000) : 32'($urandom_range(0, 255));
            w = 1'($urandom);
            s = 2'($urandom);
            d = $urandom;
            model(a, w, s, d, m_acc, m_be, m_wd, m_rd, m_ra);
            xact(a, w, s, d, o);
            chk($sformatf("r%0d latency a=%h", t, a), 32'(o.lat), 32'(WC + (w ? 2 : 3)));
            chk($sformatf("r%0d ram_en count a=%h", t, a), 32'(o.n_en), 32'(m_acc));
            if (m_acc) begin
                chk($sformatf("r%0d ram_be a=%h s=%0d", t, a, s), 32'(o.be), 32'(m_be));
                chk($sformatf("r%0d ram_addr a=%h", t, a), 32'(o.ra), 32'(m_ra));
                chk($sformatf("r%0d ram_we", t), 32'(o.we), 32'(w));
                if (w) chk($sformatf("r%0d ram_wdata s=%0d", t, s), o.wd, m_wd);
            end
            chk($sformatf("r%0d DDT_OE", t), 32'(o.oe), 32'(!w));
            if (!w) chk($sformatf("r%0d DDT_R a=%h", t, a), o.rd, m_rd);
            chk($sformatf("r%0d ack release", t), 32'(o.rel), 32'd1);
`ifdef DMEM_ERR_EN
            chk($sformatf("r%0d err a=%h s=%0d", t, a, s), 32'(o.er), 32'(!m_acc));
`endif
        end

        // Zero-wait instance, MREQ held high, DAD advancing one word... per cycle
        @(negedge clk);
        for (int c = 0; c < 46; c++) begin
            MREQ_b = c < 40;
            DAD_b = 32'(c * 4);
            @(negedge clk);
            if (ram_en_b) begin
                ens.push_back(ram_addr_b);
                chk($sformatf("b2b ram_we c=%0d", c), 32'(ram_we_b), 32'd0);
            end
            if (!ACKD_n_b) begin
                acks.push_back(c);
                chk($sformatf("b2b DDT_OE c=%0d", c), 32'(DDT_OE_b), 32'd1);
                chk($sformatf("b2b DDT_R c=%0d", c), DDT_R_b, 32'd0);
            end
        end
        MREQ_b = 1'b0;
        chk("b2b ack count", 32'(acks.size()), 32'd10);
        chk("b2b ram_en vs ack count", 32'(ens.size()), 32'(acks.size()));
        if (acks.size() > 0) chk("b2b first ack", 32'(acks[0]), 32'd3);
        if (ens.size() > 0) chk("b2b first addr", 32'(ens[0]), 32'd0);
        for (int i = 1; i < acks.size(); i++) chk($sformatf("b2b ack gap %0d", i), 32'(acks[i] - acks[i-1]), 32'd4);
        for (int i = 1; i < ens.size(); i++) chk($sformatf("b2b addr step %0d", i), 32'(ens[i] - ens[i-1]), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-side memory controller directly downstream of the pipeline's data bus: DAD, MREQ, WRITE, SIZE, DDT (split into in/out), ACKD_n.
- Accepts one request at a time and inserts WAIT_CYCLES wait states.
- Steers store data and byte enables onto a word-wide synchronous SRAM (1-cycle read latency).
- Returns the read word and completes each access with a one-cycle active-low ACKD_n pulse.

Parameters:
ADDR_W, 12, SRAM word-address width (depth 2^ADDR_W words)
BASE, 32'h0000_0000, byte base address of the window; must be aligned to 2^(ADDR_W+2)
WAIT_CYCLES, 1, wait states inserted before the SRAM access (0..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
DAD  in  32  byte address from the mem stage
MREQ  in  1  request valid
WRITE  in  1  1 = store, 0 = load
SIZE  in  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word)
DDT_W  in  32  store data, right-justified
DDT_R  out  32  load data: full aligned word, unshifted
DDT_OE  out  1  high while DDT_R is valid (ACK cycle of a load)
ACKD_n  out  1  access-complete strobe, active-low
ram_en  out  1  SRAM enable
ram_we  out  1  SRAM write enable
ram_be  out  4  byte enables; be[3] = bits 31:24
ram_addr  out  ADDR_W  word address
ram_wdata  out  32  lane-replicated store data
ram_rdata  in  32  SRAM read data, valid one cycle after ram_en

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE; ACKD_n=1; DDT_OE=0; DDT_R=0; ram_en=0; ram_we=0; ram_be=0; ram_addr=0; ram_wdata=0.
  - Reset mid-access abandons the access. Any pending write is not issued if reset arrives before the ACCESS cycle.
- FSM states: IDLE, WAIT, ACCESS, RDATA, ACK.
- IDLE:
  - On MREQ=1, latch DAD, SIZE, WRITE and DDT_W, and load wcnt=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT: decrement wcnt each cycle; go to ACCESS when wcnt reaches 1.
- ACCESS (one cycle):
  - ram_en=1 and ram_addr=latched DAD[ADDR_W+1:2].
  - For a write: ram_we=1 and ram_be per lane rule. For a read: ram_we=0 and ram_be=4'b1111.
  - Next state is RDATA for a read, ACK for a write.
- RDATA: register ram_rdata into DDT_R; go to ACK.
- ACK (one cycle):
  - ACKD_n=0; DDT_OE=1 if the access is a read.
  - Return to IDLE. A new MREQ is sampled in IDLE the next cycle.
- Access latency from the MREQ sample to ACKD_n low:
  - Read: WAIT_CYCLES+3 cycles.
  - Write: WAIT_CYCLES+2 cycles.
- MREQ changes outside IDLE are ignored; the latched request is authoritative.
- Lane rule (big-endian; offset = DAD[1:0]):
  - word: be=1111, wdata=DDT_W.
  - half: offset[1]=0 -> be=1100, =1 -> be=0011; wdata={2{DDT_W[15:0]}}.
  - byte: be=1000>>offset; wdata={4{DDT_W[7:0]}}.
- Out of window (DAD[31:ADDR_W+2] != BASE[31:ADDR_W+2]):
  - No ram_en is issued. Reads return DDT_R=0. The ACK still occurs with normal latency.
- Misalignment handling depends on DMEM_ERR_EN (below).

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - A misaligned request (half with DAD[0]=1, or word with DAD[1:0]!=0) or an out-of-window request issues no SRAM access.
  - err=1 during its ACK cycle only.
- Undefined:
  - No err port.
  - Misaligned low bits are ignored: word forced to offset 0, half to DAD[1].
  - Out-of-window requests behave as described in Behaviour.

Decomposition:
- Package dmem_pkg holds:
  - SIZE encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
  - FSM state encoding.
  - Constant WCNT_W=4.
- One sub-module: dmem_lane — combinational lane steering (size, offset, wdata in -> be, wdata out, misaligned flag).

Test Plan:
- WAIT_CYCLES=1: word write DAD=0x10, DDT_W=0xDEADBEEF, then read 0x10 -> write ACKD_n low 3 cycles after the MREQ sample; read ACK 4 cycles after it; DDT_R=0xDEADBEEF with DDT_OE=1 on the ACK cycle.
- Byte write DAD=0x13, DDT_W=0x000000A5 -> ram_be=0001, ram_wdata=0xA5A5A5A5. Subsequent word read of 0x10 returns 0xDEADBEA5.
- Half write DAD=0x20, DDT_W=0x1234 -> ram_be=1100, ram_wdata=0x12341234, ram_addr=8.
- Read DAD outside the window (e.g. 0x8000_0000 with ADDR_W=12, BASE=0) -> no ram_en; ACKD_n pulses; DDT_R=0. With DMEM_ERR_EN, err=1 on the ACK cycle.
- rst=0 asserted in the WAIT state of a write -> no ram_we ever asserted; all outputs at reset values the next cycle; the next MREQ is serviced normally.
- WAIT_CYCLES=0, back-to-back reads with MREQ held high -> ACK every 4 cycles; each latched address serviced exactly once.
